// File: rtl/imem_loader.sv
// Instruction-memory loader: framed host byte stream to 32-bit words at address 0 and up.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WR,
        DONE,
        ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        CHK
`endif
    } state_t;

    state_t            state;
    logic [15:0]       len;
    logic [1:0]        bcnt;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    logic        xfer;
    logic [16:0] n_new;
    logic        last;
    logic [31:0] word_nxt;

    assign xfer     = in_valid & in_ready;
    assign n_new    = {1'b0, len[15:8], in_data};
    assign last     = (17'(idx) == ({1'b0, len} - 17'd1));
    assign word_nxt = {word[23:0], in_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            len      <= '0;
            bcnt     <= '0;
            idx      <= '0;
            word     <= '0;
            in_ready <= 1'b0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            im_we <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                IDLE, ERR: begin
                    if (start) begin
                        state    <= LEN_HI;
                        err      <= 1'b0;
                        idx      <= '0;
                        bcnt     <= '0;
                        cpu_hold <= 1'b1;
                        in_ready <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= in_data;
                        state     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= in_data;
                        if (n_new == 17'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state    <= CHK;
`else
                            state    <= DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
`endif
                        end else if (n_new > 17'(DEPTH)) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        word <= word_nxt;
                        bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum ^ in_data;
`endif
                        if (bcnt == 2'd3) begin
                            state    <= WR;
                            in_ready <= 1'b0;
                            im_we    <= 1'b1;
                            im_addr  <= idx;
                            im_wdata <= word_nxt;
                        end
                    end
                end
                WR: begin
                    if (last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state    <= CHK;
                        in_ready <= 1'b1;
`else
                        state <= DONE;
                        done  <= 1'b1;
`endif
                    end else begin
                        idx      <= idx + ADDR_W'(1);
                        state    <= DATA;
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    cpu_hold <= 1'b0;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at stimulus, popped by a monitor.
// Checksum cases are enabled together with IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    localparam int AW = 10;
    localparam logic [7:0] CSUM = 8'hAC;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;

    imem_loader #(.ADDR_W(AW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .im_we(im_we),
        .im_addr(im_addr),
        .im_wdata(im_wdata),
        .cpu_hold(cpu_hold),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t  expq[$];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    logic prev_we = 1'b0;
    wr_t  mon_e;

    logic [7:0] frm [0:9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            prev_we = 1'b0;
        end else begin
            if (im_we) begin
                check("we_not_back_to_back", 32'(prev_we), 32'd0);
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr %0h data %08h, none expected",
                             im_addr, im_wdata);
                end else begin
                    mon_e = expq.pop_front();
                    check("wr_addr", 32'(im_addr), 32'(mon_e.a));
                    check("wr_data", im_wdata, mon_e.d);
                end
            end
            if (done) done_cnt++;
            prev_we = im_we;
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte %02h got in_ready 0 expected 1", b);
        end
    endtask

    task automatic trailer(input logic [7:0] c, input int gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(c, gap);
`else
        if (c != c) send(c, gap);
`endif
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends the first nbytes of the reference frame, queuing each word
    // as its last byte is issued; optionally pulses start before byte sp.
    task automatic send_frame(input int gap, input int nbytes, input int sp);
        for (int i = 0; i < nbytes; i++) begin
            if (i == sp) start_pulse();
            if (i == 5) expq.push_back('{a: AW'(0), d: 32'h20080005});
            if (i == 9) expq.push_back('{a: AW'(1), d: 32'h8C090004});
            send(frm[i], gap);
        end
    endtask

    task automatic wait_done(input string name);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check(name, 32'(got), 32'd1);
        check({name, "_hold_in_done"}, 32'(cpu_hold), 32'd1);
        @(negedge clk);
        check({name, "_hold_after"}, 32'(cpu_hold), 32'd0);
        check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int d0;
        logic [7:0] bb;
        logic [7:0] cs;
        logic [31:0] w;

        frm[0] = 8'h00; frm[1] = 8'h02;
        frm[2] = 8'h20; frm[3] = 8'h08; frm[4] = 8'h00; frm[5] = 8'h05;
        frm[6] = 8'h8C; frm[7] = 8'h09; frm[8] = 8'h00; frm[9] = 8'h04;

        #12;
        check("reset_ctrl", 32'({in_ready, im_we, cpu_hold, done, err}), 32'd0);
        check("reset_bus", 32'(im_addr) | im_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (3) @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd0);
        check("idle_hold", 32'(cpu_hold), 32'd0);
        in_valid = 1'b0;

        // Basic frame, host valid every cycle
        start_pulse();
        check("lenhi_hold", 32'(cpu_hold), 32'd1);
        check("lenhi_ready", 32'(in_ready), 32'd1);
        d0 = done_cnt;
        send_frame(0, 10, -1);
        trailer(CSUM, 0);
        wait_done("basic_done");
        check("basic_done_count", 32'(done_cnt - d0), 32'd1);
        check("basic_err", 32'(err), 32'd0);

        // Same frame with a stalling host
        start_pulse();
        d0 = done_cnt;
        send_frame(1, 10, -1);
        trailer(CSUM, 1);
        wait_done("stall_done");
        check("stall_done_count", 32'(done_cnt - d0), 32'd1);

        // Empty program
        start_pulse();
        send(8'h00, 0);
        send(8'h00, 0);
        trailer(8'h00, 0);
        wait_done("empty_done");
        check("empty_err", 32'(err), 32'd0);

        // Oversize length
        start_pulse();
        d0 = done_cnt;
        send(8'h04, 0);
        send(8'h01, 0);
        repeat (2) @(negedge clk);
        check("over_err", 32'(err), 32'd1);
        check("over_hold", 32'(cpu_hold), 32'd1);
        check("over_ready", 32'(in_ready), 32'd0);
        check("over_no_done", 32'(done_cnt - d0), 32'd0);
        start_pulse();
        check("restart_err_clear", 32'(err), 32'd0);
        check("restart_hold", 32'(cpu_hold), 32'd1);
        send(8'h00, 0);
        send(8'h00, 0);
        trailer(8'h00, 0);
        wait_done("restart_done");

        // Full-depth load: last write lands at DEPTH-1
        start_pulse();
        send(8'h04, 0);
        send(8'h00, 0);
        cs = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            w = 32'hA5000000 | 32'(i);
            expq.push_back('{a: AW'(i), d: w});
            for (int k = 3; k >= 0; k--) begin
                bb = w[k*8 +: 8];
                cs = cs ^ bb;
                send(bb, 0);
            end
        end
        trailer(cs, 0);
        wait_done("full_done");
        check("full_err", 32'(err), 32'd0);

        // Reset after 6 of 8 data bytes
        start_pulse();
        send_frame(0, 8, -1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_ctrl", 32'({in_ready, im_we, cpu_hold, done, err}), 32'd0);
        check("midrst_bus", 32'(im_addr) | im_wdata, 32'd0);
        check("midrst_first_word_seen", 32'(expq.size()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        start_pulse();
        send_frame(0, 10, -1);
        trailer(CSUM, 0);
        wait_done("reload_done");

        // Start during DATA is ignored
        start_pulse();
        d0 = done_cnt;
        send_frame(0, 10, 4);
        trailer(CSUM, 0);
        wait_done("midstart_done");
        check("midstart_done_count", 32'(done_cnt - d0), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum: words land, no done, err set
        start_pulse();
        d0 = done_cnt;
        send_frame(0, 10, -1);
        send(8'h00, 0);
        repeat (3) @(negedge clk);
        check("badsum_err", 32'(err), 32'd1);
        check("badsum_no_done", 32'(done_cnt - d0), 32'd0);
        check("badsum_hold", 32'(cpu_hold), 32'd1);
`endif

        repeat (3) @(negedge clk);
        check("all_writes_seen", 32'(expq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached, expected summary");
        $fatal(1);
    end

endmodule
